// File: rtl/norm_output_writer_if.sv
// norm_output_writer_if: column stream in from the norm stage and BRAM write port out.
interface norm_output_writer_if #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4
);
    logic                           in_data_available;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]          validity_mask;
    logic [AWIDTH-1:0]              bram_addr;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata;
    logic [MAT_MUL_SIZE-1:0]        bram_we;
    modport master (
        output in_data_available, inp_data, validity_mask,
        input  bram_addr, bram_wdata, bram_we
    );
    modport slave (
        input  in_data_available, inp_data, validity_mask,
        output bram_addr, bram_wdata, bram_we
    );
endinterface

// File: rtl/norm_output_writer.sv
// norm_output_writer: writes one tile of MAT_MUL_SIZE norm columns to BRAM at start + k*stride.
module norm_output_writer #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_write,
    input  logic [AWIDTH-1:0]  start_addr,
    input  logic [AWIDTH-1:0]  address_stride,
    norm_output_writer_if.slave io,
    output logic               done_write,
    output logic               busy
);
    localparam int CW = $clog2(MAT_MUL_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(MAT_MUL_SIZE - 1);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t                         state;
    logic [CW-1:0]                  col_cnt;
    logic [AWIDTH-1:0]              next_addr, stride_q, base, step;
    logic [MASK_WIDTH-1:0]          mask;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] masked;
    logic                           accept, last;
    assign mask   = io.validity_mask;
    assign accept = io.in_data_available && state != DONE;
    assign last   = col_cnt == LAST;
    // In IDLE the live start/stride ports seed the tile; afterwards only the latched copies are used.
    assign base   = state == IDLE ? start_addr : next_addr;
    assign step   = state == IDLE ? address_stride : stride_q;
    for (genvar i = 0; i < MAT_MUL_SIZE; i++) begin : g_lane
        assign masked[i*DWIDTH +: DWIDTH] = mask[i] ? io.inp_data[i*DWIDTH +: DWIDTH] : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            col_cnt       <= '0;
            next_addr     <= '0;
            stride_q      <= '0;
            io.bram_addr  <= '0;
            io.bram_wdata <= '0;
            io.bram_we    <= '0;
            done_write    <= 1'b0;
            busy          <= 1'b0;
        end else if (!enable_write) begin
            state         <= IDLE;
            col_cnt       <= '0;
            next_addr     <= '0;
            stride_q      <= '0;
            io.bram_addr  <= '0;
            io.bram_wdata <= '0;
            io.bram_we    <= '0;
            done_write    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            io.bram_we <= '0;
            if (accept) begin
                io.bram_addr  <= base;
                io.bram_wdata <= masked;
                io.bram_we    <= mask[MAT_MUL_SIZE-1:0];
                next_addr     <= base + step;
                stride_q      <= step;
                col_cnt       <= col_cnt + 1'b1;
                state         <= last ? DONE : WRITE;
                busy          <= !last;
                done_write    <= last;
            end
        end
    end
endmodule

// File: tb/tb_norm_output_writer.sv
// tb_norm_output_writer: table-driven vectors plus hand-written reset/abort sequences.
module tb_norm_output_writer;
    logic        clk = 0;
    logic        reset = 1;
    logic        enable_write = 0;
    logic [9:0]  start_addr = '0;
    logic [9:0]  address_stride = '0;
    logic        done_write, busy;
    int          checks = 0;
    int          errors = 0;
    norm_output_writer_if #(.DWIDTH(8), .MAT_MUL_SIZE(4), .AWIDTH(10), .MASK_WIDTH(4)) io ();
    norm_output_writer #(.DWIDTH(8), .MAT_MUL_SIZE(4), .AWIDTH(10), .MASK_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable_write(enable_write), .start_addr(start_addr),
        .address_stride(address_stride), .io(io.slave), .done_write(done_write), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        en, av;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [9:0]  start, stride;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_we;
        logic        e_done, e_busy;
    } vec_t;
    vec_t vq[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_out(input string tag, input logic [9:0] a, input logic [31:0] w,
                              input logic [3:0] we, input logic d, input logic b);
        chk({tag, ".addr"}, 32'(io.bram_addr), 32'(a));
        chk({tag, ".wdata"}, io.bram_wdata, w);
        chk({tag, ".we"}, 32'(io.bram_we), 32'(we));
        chk({tag, ".done"}, 32'(done_write), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask
    task automatic cyc(input logic en, input logic av, input logic [31:0] data, input logic [3:0] mask,
                       input logic [9:0] st, input logic [9:0] sd);
        enable_write = en;
        io.in_data_available = av;
        io.inp_data = data;
        io.validity_mask = mask;
        start_addr = st;
        address_stride = sd;
        @(posedge clk);
        #1;
    endtask
    initial begin
        io.in_data_available = 0;
        io.inp_data = '0;
        io.validity_mask = '0;
        // idle, back-to-back tile at 0x010 stride 1, late pulse ignored, then disable
        vq.push_back('{1, 0, 32'h0, 4'hF, 10'h010, 10'd1, 10'h000, 32'h0, 4'h0, 0, 0});
        vq.push_back('{1, 1, 32'h04030201, 4'hF, 10'h010, 10'd1, 10'h010, 32'h04030201, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h08070605, 4'hF, 10'h010, 10'd1, 10'h011, 32'h08070605, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h0C0B0A09, 4'hF, 10'h010, 10'd1, 10'h012, 32'h0C0B0A09, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h100F0E0D, 4'hF, 10'h010, 10'd1, 10'h013, 32'h100F0E0D, 4'hF, 1, 0});
        vq.push_back('{1, 1, 32'hDEADBEEF, 4'hF, 10'h010, 10'd1, 10'h013, 32'h100F0E0D, 4'h0, 1, 0});
        vq.push_back('{0, 0, 32'h0, 4'hF, 10'h010, 10'd1, 10'h000, 32'h0, 4'h0, 0, 0});
        // gapped stream, stride 8, mid-tile start/stride change ignored
        vq.push_back('{1, 1, 32'h11111111, 4'hF, 10'h010, 10'd8, 10'h010, 32'h11111111, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h22222222, 4'hF, 10'h200, 10'd3, 10'h018, 32'h22222222, 4'hF, 0, 1});
        vq.push_back('{1, 0, 32'h0, 4'hF, 10'h200, 10'd3, 10'h018, 32'h22222222, 4'h0, 0, 1});
        vq.push_back('{1, 0, 32'h0, 4'hF, 10'h200, 10'd3, 10'h018, 32'h22222222, 4'h0, 0, 1});
        vq.push_back('{1, 1, 32'h33333333, 4'hF, 10'h200, 10'd3, 10'h020, 32'h33333333, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h44444444, 4'hF, 10'h200, 10'd3, 10'h028, 32'h44444444, 4'hF, 1, 0});
        vq.push_back('{1, 1, 32'h55555555, 4'hF, 10'h200, 10'd3, 10'h028, 32'h44444444, 4'h0, 1, 0});
        vq.push_back('{0, 0, 32'h0, 4'hF, 10'h000, 10'd0, 10'h000, 32'h0, 4'h0, 0, 0});
        // masking, including an all-zero mask column that still advances
        vq.push_back('{1, 1, 32'hAABBCCDD, 4'b0101, 10'h100, 10'd1, 10'h100, 32'h00BB00DD, 4'b0101, 0, 1});
        vq.push_back('{1, 1, 32'h11223344, 4'b0000, 10'h100, 10'd1, 10'h101, 32'h00000000, 4'b0000, 0, 1});
        vq.push_back('{1, 0, 32'h0, 4'hF, 10'h100, 10'd1, 10'h101, 32'h00000000, 4'b0000, 0, 1});
        vq.push_back('{1, 1, 32'h55667788, 4'b1010, 10'h100, 10'd1, 10'h102, 32'h55007700, 4'b1010, 0, 1});
        vq.push_back('{1, 1, 32'h99AABBCC, 4'b1111, 10'h100, 10'd1, 10'h103, 32'h99AABBCC, 4'b1111, 1, 0});
        vq.push_back('{0, 0, 32'h0, 4'hF, 10'h000, 10'd0, 10'h000, 32'h0, 4'h0, 0, 0});
        // address wrap modulo 2^10
        vq.push_back('{1, 1, 32'h01010101, 4'hF, 10'h3FE, 10'd1, 10'h3FE, 32'h01010101, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h02020202, 4'hF, 10'h3FE, 10'd1, 10'h3FF, 32'h02020202, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h03030303, 4'hF, 10'h3FE, 10'd1, 10'h000, 32'h03030303, 4'hF, 0, 1});
        vq.push_back('{1, 1, 32'h04040404, 4'hF, 10'h3FE, 10'd1, 10'h001, 32'h04040404, 4'hF, 1, 0});
        vq.push_back('{0, 0, 32'h0, 4'hF, 10'h000, 10'd0, 10'h000, 32'h0, 4'h0, 0, 0});
        repeat (2) @(posedge clk);
        #1 reset = 0;
        expect_out("reset", 10'h0, 32'h0, 4'h0, 0, 0);
        foreach (vq[n]) begin
            cyc(vq[n].en, vq[n].av, vq[n].data, vq[n].mask, vq[n].start, vq[n].stride);
            expect_out($sformatf("vec%0d", n), vq[n].e_addr, vq[n].e_wdata, vq[n].e_we, vq[n].e_done, vq[n].e_busy);
        end
        // asynchronous reset mid-tile clears outputs before the next edge
        cyc(1, 1, 32'hCAFEF00D, 4'hF, 10'h055, 10'd1);
        expect_out("pre_areset", 10'h055, 32'hCAFEF00D, 4'hF, 0, 1);
        #3 reset = 1;
        #1 expect_out("areset", 10'h0, 32'h0, 4'h0, 0, 0);
        #1 reset = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'h0, 4'hF, 10'h055, 10'd1);
            expect_out($sformatf("idle%0d", k), 10'h0, 32'h0, 4'h0, 0, 0);
        end
        // abort after two columns, then a fresh tile from 0x040
        cyc(1, 1, 32'hA1A1A1A1, 4'hF, 10'h080, 10'd2);
        expect_out("ab0", 10'h080, 32'hA1A1A1A1, 4'hF, 0, 1);
        cyc(1, 1, 32'hA2A2A2A2, 4'hF, 10'h080, 10'd2);
        expect_out("ab1", 10'h082, 32'hA2A2A2A2, 4'hF, 0, 1);
        cyc(0, 1, 32'hA3A3A3A3, 4'hF, 10'h080, 10'd2);
        expect_out("abort", 10'h0, 32'h0, 4'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, {4{8'(8'hB0 + k)}}, 4'hF, 10'h040, 10'd1);
            expect_out($sformatf("re%0d", k), 10'(10'h040 + k), {4{8'(8'hB0 + k)}}, 4'hF, k == 3, k != 3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/norm_output_writer.md
Name: norm_output_writer

Overview:
- Consumer end of the normalization stage's column stream.
- Accepts one MAT_MUL_SIZE-wide column per cycle while `in_data_available` is high (driven by the norm block's `out_data_available`).
- Registers each column and writes it to the output BRAM port at `start_addr + k*address_stride`.
- Counts columns; signals `done_write` after MAT_MUL_SIZE columns have been written.
- Sits between the norm stage and the output BRAM of the matmul datapath.

Parameters:
- DWIDTH, 8, bits per data element
- MAT_MUL_SIZE, 4, elements per column and columns per tile
- AWIDTH, 10, BRAM address width
- MASK_WIDTH, 4, validity mask width; equals MAT_MUL_SIZE

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- enable_write  input  1  block enable; low forces IDLE and clears outputs synchronously
- start_addr  input  AWIDTH  BRAM address of column 0; sampled on the first accepted column
- address_stride  input  AWIDTH  address increment between columns; sampled with start_addr
- in_data_available  input  1  column valid this cycle
- inp_data  input  MAT_MUL_SIZE*DWIDTH  column data; lane i at [i*DWIDTH +: DWIDTH]
- validity_mask  input  MASK_WIDTH  lane i written only if bit i = 1
- bram_addr  output  AWIDTH  write address
- bram_wdata  output  MAT_MUL_SIZE*DWIDTH  write data; masked lanes driven 0
- bram_we  output  MAT_MUL_SIZE  per-lane write enable
- done_write  output  1  tile fully written; held until enable_write drops
- busy  output  1  high in WRITE state

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE
  - bram_addr = 0, bram_wdata = 0, bram_we = 0
  - done_write = 0, busy = 0
  - column counter = 0
- enable_write = 0 has the same effect as reset, applied synchronously at the next edge.
- States:
  - IDLE: waits for a column.
    - in_data_available = 1 → WRITE; column 0 captured; start_addr and address_stride latched.
  - WRITE: each edge with in_data_available = 1 captures the next column.
    - in_data_available = 0 (stall/gap) → bram_we = 0 next cycle; counter and address hold.
    - When the MAT_MUL_SIZE-th column is captured → DONE.
  - DONE: done_write = 1 and busy = 0.
    - Further in_data_available pulses are ignored: no writes, no address change.
    - Stays in DONE until enable_write = 0, then goes to IDLE.
- Latency:
  - A column sampled at edge N appears on bram_addr/bram_wdata/bram_we in the cycle after edge N.
  - One write per accepted column, no bubbles inserted.
- Address sequence:
  - Column k is written at latched_start + k*latched_stride.
  - Arithmetic is modulo 2^AWIDTH; wrap-around is silent.
  - Implemented as a running adder, not a multiplier.
- Masking:
  - bram_we[i] = validity_mask[i] sampled with the column.
  - bram_wdata lane i = 0 when mask bit i = 0.
  - A column with an all-zero mask still counts and still advances the address, with bram_we = 0.
- done_write asserts in the same cycle the last column's write is presented (edge after last capture).
- bram_we is a single-cycle pulse per column; it is 0 in every cycle with no newly captured column.
- A start_addr or address_stride change mid-tile has no effect until the next IDLE → WRITE transition.
- Reset or enable_write drop mid-tile:
  - Aborts the tile; remaining columns are not written.
  - Next stream restarts at column 0.
- Stream shorter than MAT_MUL_SIZE columns: block remains in WRITE indefinitely (no timeout).

Test Plan:
- Reset/idle check: reset asserted asynchronously mid-cycle → all outputs 0 immediately; after release with enable_write = 1 and no data, bram_we stays 0 and done_write stays 0.
- Back-to-back columns: start_addr = 0x010, stride = 1, mask = 4'hF, 4 consecutive columns 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D → writes at 0x010..0x013 on the 4 cycles after each capture; done_write = 1 with the 4th write.
- Gapped stream plus late DONE input: columns with 2 idle cycles between columns 1 and 2, stride = 8 → addresses 0x010, 0x018, 0x020, 0x028; bram_we low during gaps; a 5th pulse after done produces no write.
- Masking: mask = 4'b0101, data 0xAABBCCDD → bram_we = 4'b0101, bram_wdata = 0x00BB00DD.
- Address wrap: AWIDTH = 10, start_addr = 0x3FE, stride = 1 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Abort: enable_write dropped after 2 of 4 columns → IDLE next edge, done_write stays 0; a new stream with start_addr = 0x040 writes from 0x040 and completes normally.
